alu_txn_driver: RTL and testbench

ALU_TXN_DRIVER -- requirements
Module: alu_txn_driver

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_txn_driver_if.sv | 26 ++
 rtl/alu_ref_model.sv | 37 +++
 rtl/alu_txn_driver.sv | 128 ++++++++++++
 tb/tb_alu_txn_driver.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU transaction driver and its reference model.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NOTA = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    RESP  = 2'b10
  } state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_txn_driver_if.sv
// Request/response handshake bundle between an upstream agent and the ALU transaction driver.
interface alu_txn_driver_if;
  import alu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [ALU_W-1:0] req_a;
  logic [ALU_W-1:0] req_b;
  logic [1:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ALU_W-1:0] rsp_y;
  logic [ALU_W-1:0] rsp_exp;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_exp, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_exp, rsp_err
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model of the external 4-bit ALU, used to judge its returned result.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       op,
  output logic [ALU_W-1:0] y
);

  logic [ALU_W-1:0] and_v;
  logic [ALU_W-1:0] or_v;
  logic [ALU_W-1:0] xor_v;
  logic [ALU_W-1:0] nota_v;

  genvar gi;
  generate
    for (gi = 0; gi < ALU_W; gi++) begin : g_bit
      assign and_v[gi]  = a[gi] & b[gi];
      assign or_v[gi]   = a[gi] | b[gi];
      assign xor_v[gi]  = a[gi] ^ b[gi];
      assign nota_v[gi] = ~a[gi];
    end
  endgenerate

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      OP_AND:  y = and_v;
      OP_OR:   y = or_v;
      OP_XOR:  y = xor_v;
      OP_NOTA: y = nota_v;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_txn_driver.sv
// Drives one request at a time onto an external ALU, waits a settle time, samples the result
// and checks it against the reference model, keeping saturating pass/mismatch statistics.
module alu_txn_driver
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_txn_driver_if.slave  bus,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [ALU_W-1:0] alu_y,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_seen,
  input  logic             clr_stats
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_reg;
  logic [3:0]       settle_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic [ALU_W-1:0] alu_a_reg;
  logic [ALU_W-1:0] alu_b_reg;
  logic [1:0]       alu_op_reg;
  logic [ALU_W-1:0] rsp_y_reg;
  logic [ALU_W-1:0] rsp_exp_reg;
  logic             rsp_err_reg;
  logic [CNT_W-1:0] txn_count_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic             err_seen_reg;
  logic [ALU_W-1:0] ref_y;
  logic             rsp_take;

  // The model sees the held operands, so its answer matches what the ALU is computing.
  alu_ref_model u_ref (
    .a  (alu_a_reg),
    .b  (alu_b_reg),
    .op (alu_op_reg),
    .y  (ref_y)
  );

  assign rsp_take = (state_reg == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      settle_reg    <= '0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      rsp_y_reg     <= '0;
      rsp_exp_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      txn_count_reg <= '0;
      err_count_reg <= '0;
      err_seen_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (bus.req_valid && req_ready_reg) begin
            alu_a_reg     <= bus.req_a;
            alu_b_reg     <= bus.req_b;
            alu_op_reg    <= bus.req_op;
            settle_reg    <= '0;
            req_ready_reg <= 1'b0;
            state_reg     <= DRIVE;
          end
        end
        DRIVE: begin
          settle_reg <= settle_reg + 4'd1;
          if (settle_reg == SETTLE_LAST) begin
            rsp_y_reg     <= alu_y;
            rsp_exp_reg   <= ref_y;
            rsp_err_reg   <= (alu_y != ref_y);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          req_ready_reg <= 1'b0;
          rsp_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase

      // A clear wins over a response completing on the same edge.
      if (clr_stats) begin
        txn_count_reg <= '0;
        err_count_reg <= '0;
        err_seen_reg  <= 1'b0;
      end else if (rsp_take) begin
        txn_count_reg <= sat_inc(txn_count_reg);
        if (rsp_err_reg) begin
          err_count_reg <= sat_inc(err_count_reg);
          err_seen_reg  <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_y     = rsp_y_reg;
  assign bus.rsp_exp   = rsp_exp_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_op        = alu_op_reg;
  assign txn_count     = txn_count_reg;
  assign err_count     = err_count_reg;
  assign err_seen      = err_seen_reg;

endmodule

// File: tb/tb_alu_txn_driver.sv
// Scoreboard bench: stimulus pushes hand-computed responses, a monitor pops and checks them.
module tb_alu_txn_driver;
  import alu_pkg::*;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [1:0] alu_op;
  logic [7:0] txn_count, err_count;
  logic       err_seen;
  logic       clr_stats;

  alu_txn_driver_if bus();

  alu_txn_driver #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .txn_count (txn_count),
    .err_count (err_count),
    .err_seen  (err_seen),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  // External ALU; frc makes it return a fixed (wrong) value.
  bit         frc = 1'b0;
  logic [3:0] frc_val = 4'h0;
  logic [3:0] good;
  always_comb begin
    good = 4'h0;
    case (alu_op)
      2'b00:   good = alu_a & alu_b;
      2'b01:   good = alu_a | alu_b;
      2'b10:   good = alu_a ^ alu_b;
      default: good = ~alu_a;
    endcase
    alu_y = frc ? frc_val : good;
  end

  typedef struct {
    logic [3:0] y;
    logic [3:0] ex;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Edge bookkeeping for latency / throughput checks.
  int   cyc = 0;
  int   acc_edge = 0;
  bit   have_acc = 1'b0;
  bit   timing_en = 1'b0;
  logic rv_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.req_valid && bus.req_ready) begin
      if (timing_en && have_acc) chk("accept_interval", cyc - acc_edge, SETTLE + 2);
      acc_edge = cyc;
      have_acc = 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (timing_en && bus.rsp_valid && !rv_prev) chk("rsp_latency", cyc - acc_edge, SETTLE);
    rv_prev = bus.rsp_valid;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got y=%h exp=%h, expected no response", bus.rsp_y, bus.rsp_exp);
      end else begin
        e = sb.pop_front();
        $display("TXN a=%h b=%h op=%0d y=%h exp=%h err=%b", alu_a, alu_b, alu_op,
                 bus.rsp_y, bus.rsp_exp, bus.rsp_err);
        chk("rsp_y", bus.rsp_y, e.y);
        chk("rsp_exp", bus.rsp_exp, e.ex);
        chk("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  // All stimulus tasks are entered and left at posedge+1.
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("rsp_valid_timeout", 0, 1);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input bit f, input logic [3:0] fv,
                      input logic [3:0] ey, input logic [3:0] eex, input logic eerr,
                      input bit keep);
    exp_t e;
    wait_ready();
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = op;
    frc = f;
    frc_val = fv;
    e.y = ey;
    e.ex = eex;
    e.err = eerr;
    sb.push_back(e);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_stats = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = 4'h0;
    bus.req_b = 4'h0;
    bus.req_op = 2'b00;
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_err_seen", err_seen, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("req_ready_before_edge", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("req_ready_after_release", bus.req_ready, 1);

    // AND with a correct ALU.
    send(4'hC, 4'hA, 2'b00, 0, 4'h0, 4'h8, 4'h8, 1'b0, 0);
    wait_ready();
    chk("txn_count_1", txn_count, 1);
    chk("err_count_0", err_count, 0);
    chk("err_seen_0", err_seen, 0);

    // NOT A with a broken ALU.
    send(4'h5, 4'h0, 2'b11, 1, 4'hF, 4'hF, 4'hA, 1'b1, 0);
    wait_ready();
    chk("txn_count_2", txn_count, 2);
    chk("err_count_1", err_count, 1);
    chk("err_seen_1", err_seen, 1);
    chk("alu_a_held", alu_a, 4'h5);
    chk("alu_op_held", alu_op, 2'b11);

    send(4'h3, 4'hC, 2'b01, 0, 4'h0, 4'hF, 4'hF, 1'b0, 0);
    send(4'h6, 4'h3, 2'b10, 0, 4'h0, 4'h5, 4'h5, 1'b0, 0);
    send(4'h9, 4'h0, 2'b11, 0, 4'h0, 4'h6, 4'h6, 1'b0, 0);
    wait_ready();
    chk("txn_count_5", txn_count, 5);
    chk("err_count_still_1", err_count, 1);

    // Response back-pressure with a competing request.
    bus.rsp_ready = 1'b0;
    send(4'h3, 4'h6, 2'b10, 0, 4'h0, 4'h5, 4'h5, 1'b0, 0);
    bus.req_valid = 1'b1;
    bus.req_a = 4'h9;
    bus.req_b = 4'h1;
    bus.req_op = 2'b01;
    wait_rsp();
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_rsp_y", bus.rsp_y, 4'h5);
      chk("stall_rsp_exp", bus.rsp_exp, 4'h5);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_alu_a", alu_a, 4'h3);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_ready();
    chk("txn_count_6", txn_count, 6);

    // Back-to-back requests: latency and acceptance spacing checked by the monitor.
    have_acc = 1'b0;
    timing_en = 1'b1;
    send(4'h1, 4'h2, 2'b01, 0, 4'h0, 4'h3, 4'h3, 1'b0, 1);
    send(4'hF, 4'hF, 2'b00, 0, 4'h0, 4'hF, 4'hF, 1'b0, 1);
    send(4'hA, 4'h5, 2'b10, 0, 4'h0, 4'hF, 4'hF, 1'b0, 1);
    send(4'h8, 4'h0, 2'b11, 0, 4'h0, 4'h7, 4'h7, 1'b0, 1);
    bus.req_valid = 1'b0;
    wait_ready();
    timing_en = 1'b0;
    chk("txn_count_10", txn_count, 10);

    // Saturation.
    for (int i = 0; i < 300; i++)
      send(4'h5, 4'h0, 2'b11, 1, 4'hF, 4'hF, 4'hA, 1'b1, 0);
    wait_ready();
    chk("txn_count_sat", txn_count, 255);
    chk("err_count_sat", err_count, 255);

    // Clear coincident with a response acceptance.
    bus.rsp_ready = 1'b0;
    send(4'h5, 4'h0, 2'b11, 1, 4'hF, 4'hF, 4'hA, 1'b1, 0);
    wait_rsp();
    bus.rsp_ready = 1'b1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    chk("clr_rsp_valid", bus.rsp_valid, 0);
    chk("clr_txn_count", txn_count, 0);
    chk("clr_err_count", err_count, 0);
    chk("clr_err_seen", err_seen, 0);

    // Reset in the middle of DRIVE.
    send(4'h7, 4'h3, 2'b00, 0, 4'h0, 4'h3, 4'h3, 1'b0, 0);
    wait_ready();
    chk("txn_count_pre_abort", txn_count, 1);
    send(4'h2, 4'h4, 2'b01, 0, 4'h0, 4'h6, 4'h6, 1'b0, 0);
    #2 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_alu_op", alu_op, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_req_ready", bus.req_ready, 0);
    chk("abort_rsp_y", bus.rsp_y, 0);
    chk("abort_rsp_exp", bus.rsp_exp, 0);
    chk("abort_txn_count", txn_count, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    chk("rel_req_ready_0", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("rel_req_ready_1", bus.req_ready, 1);
    repeat (SETTLE + 2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
